// File: rtl/ecc_lane_io_wrapper_if.sv
// Lane I/O and core-side bundle for the ECC point-multiply wrapper.
// slave is the wrapper view, master is the host/core view.
interface ecc_lane_io_wrapper_if #(
    parameter int MAX_BITS = 128,
    parameter int LANES    = 1
);
    logic                i_data_valid;
    logic                i_reload;
    logic                i_mode;
    logic [LANES-1:0]    i_a;
    logic [LANES-1:0]    i_prime;
    logic [LANES-1:0]    i_mul;
    logic [LANES-1:0]    i_px;
    logic [LANES-1:0]    i_py;
    logic                i_out_ready;
    logic                o_data_valid;
    logic [LANES-1:0]    o_px;
    logic [LANES-1:0]    o_py;
    logic                o_busy;
    logic                o_err;
    logic                core_start;
    logic [1:0]          core_mode;
    logic [MAX_BITS-1:0] core_a;
    logic [MAX_BITS-1:0] core_prime;
    logic [MAX_BITS-1:0] core_mul;
    logic [MAX_BITS-1:0] core_px;
    logic [MAX_BITS-1:0] core_py;
    logic [MAX_BITS-1:0] core_x;
    logic [MAX_BITS-1:0] core_y;
    logic                core_done;

    modport slave (
        input  i_data_valid, i_reload, i_mode,
        input  i_a, i_prime, i_mul, i_px, i_py,
        input  i_out_ready, core_x, core_y, core_done,
        output o_data_valid, o_px, o_py, o_busy, o_err,
        output core_start, core_mode, core_a, core_prime,
        output core_mul, core_px, core_py
    );

    modport master (
        output i_data_valid, i_reload, i_mode,
        output i_a, i_prime, i_mul, i_px, i_py,
        output i_out_ready, core_x, core_y, core_done,
        input  o_data_valid, o_px, o_py, o_busy, o_err,
        input  core_start, core_mode, core_a, core_prime,
        input  core_mul, core_px, core_py
    );
endinterface

// File: rtl/ecc_lane_io_wrapper.sv
// Serial/lane front-end for the ECC point-multiply core; curve stays resident.
// Optional CAL watchdog enabled by defining ECC_WRAP_TIMEOUT_EN.
module ecc_lane_io_wrapper #(
    parameter int MAX_BITS       = 128,
    parameter int LANES          = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                  clk,
    input logic                  rst,
    ecc_lane_io_wrapper_if.slave io
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MODE_IN = 3'd1;
    localparam logic [2:0] FULL_IN = 3'd2;
    localparam logic [2:0] PT_IN   = 3'd3;
    localparam logic [2:0] CAL     = 3'd4;
    localparam logic [2:0] OUT     = 3'd5;
    localparam int         IW      = $clog2(MAX_BITS);

    logic [2:0]          state;
    logic [1:0]          mode;
    logic                mode_hi;
    logic                loaded;
    logic                start_q;
    logic                err_q;
    logic                timeout;
    logic [8:0]          cnt;
    logic [MAX_BITS-1:0] a_q, prime_q, mul_q, px_q, py_q;
    logic [MAX_BITS-1:0] rx_q, ry_q, mask;
    logic [IW-1:0]       top;
    int                  wid;

    function automatic int width_of(input logic [1:0] m);
        return 16 << m;
    endfunction

    function automatic logic [8:0] beats_of(input logic [1:0] m);
        return 9'(width_of(m) / LANES);
    endfunction

    assign wid = width_of(mode);
    assign top = IW'(wid - 1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_BITS; i++) mask[i] = (i < wid);
    end

`ifdef ECC_WRAP_TIMEOUT_EN
    logic [31:0] tcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              tcnt <= '0;
        else if (state == CAL) tcnt <= tcnt + 32'd1;
        else                   tcnt <= '0;
    end

    assign timeout = (tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode    <= 2'b01;
            mode_hi <= 1'b0;
            loaded  <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            a_q     <= '0;
            prime_q <= '0;
            mul_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: if (io.i_data_valid) begin
                    px_q <= '0;
                    py_q <= '0;
                    if (io.i_reload || !loaded) begin
                        a_q     <= '0;
                        prime_q <= '0;
                        mul_q   <= '0;
                        cnt     <= 9'd2;
                        state   <= MODE_IN;
                    end else begin
                        cnt   <= beats_of(mode);
                        state <= PT_IN;
                    end
                end
                MODE_IN: if (cnt == 9'd2) begin
                    mode_hi <= io.i_mode;
                    cnt     <= 9'd1;
                end else if (width_of({mode_hi, io.i_mode}) > MAX_BITS) begin
                    // illegal width: keep old mode, force a full reload next time
                    err_q  <= 1'b1;
                    loaded <= 1'b0;
                    state  <= IDLE;
                end else begin
                    mode  <= {mode_hi, io.i_mode};
                    cnt   <= beats_of({mode_hi, io.i_mode});
                    state <= FULL_IN;
                end
                FULL_IN: begin
                    a_q     <= {a_q[MAX_BITS-LANES-1:0], io.i_a};
                    prime_q <= {prime_q[MAX_BITS-LANES-1:0], io.i_prime};
                    mul_q   <= {mul_q[MAX_BITS-LANES-1:0], io.i_mul};
                    px_q    <= {px_q[MAX_BITS-LANES-1:0], io.i_px};
                    py_q    <= {py_q[MAX_BITS-LANES-1:0], io.i_py};
                    cnt     <= cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        loaded  <= 1'b1;
                        start_q <= 1'b1;
                        state   <= CAL;
                    end
                end
                PT_IN: begin
                    px_q <= {px_q[MAX_BITS-LANES-1:0], io.i_px};
                    py_q <= {py_q[MAX_BITS-LANES-1:0], io.i_py};
                    cnt  <= cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        start_q <= 1'b1;
                        state   <= CAL;
                    end
                end
                CAL: if (io.core_done) begin
                    rx_q  <= io.core_x & mask;
                    ry_q  <= io.core_y & mask;
                    cnt   <= beats_of(mode);
                    state <= OUT;
                end else if (timeout) begin
                    err_q <= 1'b1;
                    state <= IDLE;
                end
                OUT: if (io.i_out_ready) begin
                    rx_q <= rx_q << LANES;
                    ry_q <= ry_q << LANES;
                    cnt  <= cnt - 9'd1;
                    if (cnt == 9'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.o_data_valid = (state == OUT);
    assign io.o_px         = rx_q[top -: LANES];
    assign io.o_py         = ry_q[top -: LANES];
    assign io.o_busy       = (state != IDLE);
    assign io.o_err        = err_q;
    assign io.core_start   = start_q;
    assign io.core_mode    = mode;
    assign io.core_a       = a_q;
    assign io.core_prime   = prime_q;
    assign io.core_mul     = mul_q;
    assign io.core_px      = px_q;
    assign io.core_py      = py_q;
endmodule

// File: tb/tb_ecc_lane_io_wrapper.sv
// Directed bench: a 128-bit/1-lane and a 64-bit/4-lane wrapper on one clock.
// Exercises full/point loads, backpressure, illegal mode, reset abort.
module tb_ecc_lane_io_wrapper;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ecc_lane_io_wrapper_if #(.MAX_BITS(128), .LANES(1)) ia ();
    ecc_lane_io_wrapper_if #(.MAX_BITS(64), .LANES(4)) ib ();

    ecc_lane_io_wrapper #(
        .MAX_BITS(128), .LANES(1), .TIMEOUT_CYCLES(65535)
    ) dut_a (.clk(clk), .rst(rst), .io(ia.slave));

    ecc_lane_io_wrapper #(
        .MAX_BITS(64), .LANES(4), .TIMEOUT_CYCLES(100)
    ) dut_b (.clk(clk), .rst(rst), .io(ib.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        ia.i_data_valid = 0; ia.i_reload = 0; ia.i_mode = 0;
        ia.i_a = 0; ia.i_prime = 0; ia.i_mul = 0; ia.i_px = 0; ia.i_py = 0;
        ia.i_out_ready = 0; ia.core_x = '0; ia.core_y = '0; ia.core_done = 0;
        ib.i_data_valid = 0; ib.i_reload = 0; ib.i_mode = 0;
        ib.i_a = 0; ib.i_prime = 0; ib.i_mul = 0; ib.i_px = 0; ib.i_py = 0;
        ib.i_out_ready = 0; ib.core_x = '0; ib.core_y = '0; ib.core_done = 0;
    endtask

    // Strobe then feed; returns in the first CAL cycle when timing is right.
    task automatic load_a(input bit rl, input bit full, input logic [1:0] md,
                          input logic [15:0] a, p, m, x, y);
        ia.i_data_valid = 1; ia.i_reload = rl;
        step();
        ia.i_data_valid = 0; ia.i_reload = 0;
        if (full) begin
            ia.i_mode = md[1]; step();
            ia.i_mode = md[0]; step();
            ia.i_mode = 0;
        end
        for (int j = 0; j < 16; j++) begin
            ia.i_a = a[15-j]; ia.i_prime = p[15-j]; ia.i_mul = m[15-j];
            ia.i_px = x[15-j]; ia.i_py = y[15-j];
            step();
        end
        ia.i_a = 0; ia.i_prime = 0; ia.i_mul = 0; ia.i_px = 0; ia.i_py = 0;
    endtask

    task automatic load_b(input bit rl, input bit full, input logic [1:0] md,
                          input logic [31:0] a, p, m, x, y, input int nb);
        ib.i_data_valid = 1; ib.i_reload = rl;
        step();
        ib.i_data_valid = 0; ib.i_reload = 0;
        if (full) begin
            ib.i_mode = md[1]; step();
            ib.i_mode = md[0]; step();
            ib.i_mode = 0;
        end
        for (int j = 0; j < nb; j++) begin
            ib.i_a = a[4*(nb-1-j) +: 4]; ib.i_prime = p[4*(nb-1-j) +: 4];
            ib.i_mul = m[4*(nb-1-j) +: 4];
            ib.i_px = x[4*(nb-1-j) +: 4]; ib.i_py = y[4*(nb-1-j) +: 4];
            step();
        end
        ib.i_a = 0; ib.i_prime = 0; ib.i_mul = 0; ib.i_px = 0; ib.i_py = 0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (ia.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL rst_valid got=%h exp=0", ia.o_data_valid); end
        total++; if (ia.o_busy !== 1'b0) begin bad++;
            $display("FAIL rst_busy got=%h exp=0", ia.o_busy); end
        total++; if (ia.o_err !== 1'b0) begin bad++;
            $display("FAIL rst_err got=%h exp=0", ia.o_err); end
        total++; if (ia.core_start !== 1'b0) begin bad++;
            $display("FAIL rst_start got=%h exp=0", ia.core_start); end
        total++; if (ia.core_mode !== 2'b01) begin bad++;
            $display("FAIL rst_mode got=%h exp=1", ia.core_mode); end
        total++; if (ib.core_a !== 64'h0) begin bad++;
            $display("FAIL rst_a got=%h exp=0", ib.core_a); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_full_load();
        logic [15:0] ex = 16'hABCD;
        logic [15:0] ey = 16'h0F0F;
        load_a(1, 1, 2'b00, 16'h0002, 16'hFFF1, 16'h0005, 16'h1234, 16'h5678);
        total++; if (ia.core_start !== 1'b1) begin bad++;
            $display("FAIL full_start got=%h exp=1", ia.core_start); end
        total++; if (ia.core_mode !== 2'b00) begin bad++;
            $display("FAIL full_mode got=%h exp=0", ia.core_mode); end
        total++; if (ia.core_a !== 128'h2) begin bad++;
            $display("FAIL full_a got=%h exp=2", ia.core_a); end
        total++; if (ia.core_prime !== 128'hFFF1) begin bad++;
            $display("FAIL full_prime got=%h exp=fff1", ia.core_prime); end
        total++; if (ia.core_mul !== 128'h5) begin bad++;
            $display("FAIL full_mul got=%h exp=5", ia.core_mul); end
        total++; if (ia.core_px !== 128'h1234) begin bad++;
            $display("FAIL full_px got=%h exp=1234", ia.core_px); end
        total++; if (ia.core_py !== 128'h5678) begin bad++;
            $display("FAIL full_py got=%h exp=5678", ia.core_py); end
        step();
        total++; if (ia.core_start !== 1'b0) begin bad++;
            $display("FAIL full_start_pulse got=%h exp=0", ia.core_start); end
        total++; if (ia.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL full_cal_valid got=%h exp=0", ia.o_data_valid); end
        ia.core_x = 128'hABCD; ia.core_y = 128'h0F0F;
        ia.core_done = 1; ia.i_out_ready = 1;
        step();
        ia.core_done = 0;
        for (int j = 0; j < 16; j++) begin
            total++; if (ia.o_data_valid !== 1'b1) begin bad++;
                $display("FAIL out_valid beat=%0d got=%h exp=1", j, ia.o_data_valid); end
            total++; if (ia.o_px !== ex[15-j] || ia.o_py !== ey[15-j]) begin bad++;
                $display("FAIL out_bits beat=%0d got=%h/%h exp=%h/%h",
                         j, ia.o_px, ia.o_py, ex[15-j], ey[15-j]); end
            step();
        end
        ia.i_out_ready = 0;
        total++; if (ia.o_data_valid !== 1'b0 || ia.o_busy !== 1'b0) begin bad++;
            $display("FAIL out_end got=%h/%h exp=0/0", ia.o_data_valid, ia.o_busy); end
    endtask

    task automatic test_point_only();
        logic [31:0] ex = 32'h12345678;
        load_b(1, 1, 2'b01, 32'h11112222, 32'h33334444, 32'h7,
               32'hCAFEF00D, 32'h0BADBEEF, 8);
        total++; if (ib.core_start !== 1'b1) begin bad++;
            $display("FAIL b_full_start got=%h exp=1", ib.core_start); end
        total++; if (ib.core_mode !== 2'b01) begin bad++;
            $display("FAIL b_full_mode got=%h exp=1", ib.core_mode); end
        total++; if (ib.core_a !== 64'h11112222) begin bad++;
            $display("FAIL b_full_a got=%h exp=11112222", ib.core_a); end
        total++; if (ib.core_px !== 64'hCAFEF00D) begin bad++;
            $display("FAIL b_full_px got=%h exp=cafef00d", ib.core_px); end
        ib.core_x = 64'hFFFFFFFF_12345678; ib.core_done = 1; ib.i_out_ready = 1;
        step();
        ib.core_done = 0;
        for (int j = 0; j < 8; j++) begin
            total++; if (ib.o_px !== ex[31-4*j -: 4]) begin bad++;
                $display("FAIL b_out beat=%0d got=%h exp=%h", j, ib.o_px, ex[31-4*j -: 4]); end
            step();
        end
        ib.i_out_ready = 0;
        total++; if (ib.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL b_out_end got=%h exp=0", ib.o_data_valid); end
        load_b(0, 0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hDEADBEEF, 32'h01234567, 8);
        total++; if (ib.core_start !== 1'b1) begin bad++;
            $display("FAIL pt_start got=%h exp=1", ib.core_start); end
        total++; if (ib.core_px !== 64'hDEADBEEF) begin bad++;
            $display("FAIL pt_px got=%h exp=deadbeef", ib.core_px); end
        total++; if (ib.core_py !== 64'h01234567) begin bad++;
            $display("FAIL pt_py got=%h exp=01234567", ib.core_py); end
        total++; if (ib.core_a !== 64'h11112222 || ib.core_prime !== 64'h33334444
                     || ib.core_mul !== 64'h7) begin bad++;
            $display("FAIL pt_curve got=%h/%h/%h exp=11112222/33334444/7",
                     ib.core_a, ib.core_prime, ib.core_mul); end
        total++; if (ib.core_mode !== 2'b01) begin bad++;
            $display("FAIL pt_mode got=%h exp=1", ib.core_mode); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ex = 32'h89ABCDEF;
        logic [31:0] ey = 32'h76543210;
        int acc = 0;
        bit rdy;
        ib.core_x = 64'h89ABCDEF; ib.core_y = 64'h76543210; ib.core_done = 1;
        step();
        ib.core_done = 0;
        for (int k = 0; k < 40 && acc < 8; k++) begin
            rdy = (k % 3 == 0);
            ib.i_out_ready = rdy;
            total++; if (ib.o_data_valid !== 1'b1) begin bad++;
                $display("FAIL bp_valid k=%0d got=%h exp=1", k, ib.o_data_valid); end
            total++; if (ib.o_px !== ex[31-4*acc -: 4] || ib.o_py !== ey[31-4*acc -: 4])
            begin bad++;
                $display("FAIL bp_beat k=%0d got=%h/%h exp=%h/%h", k, ib.o_px,
                         ib.o_py, ex[31-4*acc -: 4], ey[31-4*acc -: 4]); end
            step();
            if (rdy) acc++;
        end
        ib.i_out_ready = 0;
        total++; if (ib.o_data_valid !== 1'b0 || ib.o_busy !== 1'b0) begin bad++;
            $display("FAIL bp_end got=%h/%h exp=0/0", ib.o_data_valid, ib.o_busy); end
    endtask

    task automatic test_illegal_mode();
        logic [15:0] ex = 16'h4321;
        ib.core_done = 1;
        step();
        ib.core_done = 0;
        total++; if (ib.o_busy !== 1'b0 || ib.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL stray_done got=%h/%h exp=0/0", ib.o_busy, ib.o_data_valid); end
        ib.i_data_valid = 1; ib.i_reload = 1;
        step();
        ib.i_data_valid = 0; ib.i_reload = 0;
        ib.i_mode = 1; step();
        ib.i_mode = 1; step();
        ib.i_mode = 0;
        total++; if (ib.o_err !== 1'b1) begin bad++;
            $display("FAIL ill_err got=%h exp=1", ib.o_err); end
        total++; if (ib.o_busy !== 1'b0) begin bad++;
            $display("FAIL ill_busy got=%h exp=0", ib.o_busy); end
        total++; if (ib.core_mode !== 2'b01) begin bad++;
            $display("FAIL ill_mode got=%h exp=1", ib.core_mode); end
        step();
        total++; if (ib.o_err !== 1'b0) begin bad++;
            $display("FAIL ill_err_pulse got=%h exp=0", ib.o_err); end
        load_b(0, 1, 2'b00, 32'hA5A5, 32'hFFF1, 32'h3, 32'h1234, 32'h5678, 4);
        total++; if (ib.core_start !== 1'b1) begin bad++;
            $display("FAIL forced_start got=%h exp=1", ib.core_start); end
        total++; if (ib.core_mode !== 2'b00) begin bad++;
            $display("FAIL forced_mode got=%h exp=0", ib.core_mode); end
        total++; if (ib.core_a !== 64'hA5A5 || ib.core_px !== 64'h1234) begin bad++;
            $display("FAIL forced_ops got=%h/%h exp=a5a5/1234", ib.core_a, ib.core_px); end
        ib.core_x = 64'h4321; ib.core_done = 1; ib.i_out_ready = 1;
        step();
        ib.core_done = 0;
        for (int j = 0; j < 4; j++) begin
            total++; if (ib.o_px !== ex[15-4*j -: 4]) begin bad++;
                $display("FAIL w16_out beat=%0d got=%h exp=%h", j, ib.o_px, ex[15-4*j -: 4]); end
            step();
        end
        ib.i_out_ready = 0;
        total++; if (ib.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL w16_end got=%h exp=0", ib.o_data_valid); end
    endtask

    task automatic test_reset_mid_out();
        load_a(0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0F0F, 16'hF0F0);
        total++; if (ia.core_start !== 1'b1) begin bad++;
            $display("FAIL a_pt_start got=%h exp=1", ia.core_start); end
        ia.core_x = 128'hFFFF; ia.core_y = 128'hFFFF;
        ia.core_done = 1; ia.i_out_ready = 1;
        step();
        ia.core_done = 0;
        for (int j = 0; j < 4; j++) step();
        total++; if (ia.o_data_valid !== 1'b1 || ia.o_px !== 1'b1) begin bad++;
            $display("FAIL beat5 got=%h/%h exp=1/1", ia.o_data_valid, ia.o_px); end
        #2 rst = 1'b0;
        #1;
        total++; if (ia.o_data_valid !== 1'b0 || ia.o_busy !== 1'b0
                     || ia.o_err !== 1'b0 || ia.core_start !== 1'b0) begin bad++;
            $display("FAIL abort_ctl got=%h/%h/%h/%h exp=0/0/0/0", ia.o_data_valid,
                     ia.o_busy, ia.o_err, ia.core_start); end
        total++; if (ia.core_mode !== 2'b01) begin bad++;
            $display("FAIL abort_mode got=%h exp=1", ia.core_mode); end
        total++; if (ia.core_px !== 128'h0 || ia.o_px !== 1'b0) begin bad++;
            $display("FAIL abort_regs got=%h/%h exp=0/0", ia.core_px, ia.o_px); end
        ia.i_out_ready = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        ia.core_done = 1;
        step();
        ia.core_done = 0;
        total++; if (ia.o_busy !== 1'b0 || ia.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL late_done got=%h/%h exp=0/0", ia.o_busy, ia.o_data_valid); end
        load_a(0, 1, 2'b00, 16'h0003, 16'hFFEF, 16'h0009, 16'h1111, 16'h2222);
        total++; if (ia.core_start !== 1'b1) begin bad++;
            $display("FAIL post_rst_start got=%h exp=1", ia.core_start); end
        total++; if (ia.core_a !== 128'h3 || ia.core_mode !== 2'b00) begin bad++;
            $display("FAIL post_rst_ops got=%h/%h exp=3/0", ia.core_a, ia.core_mode); end
        ia.core_x = '0; ia.core_y = '0; ia.core_done = 1; ia.i_out_ready = 1;
        step();
        ia.core_done = 0;
        for (int j = 0; j < 16; j++) step();
        ia.i_out_ready = 0;
        total++; if (ia.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL post_rst_end got=%h exp=0", ia.o_data_valid); end
    endtask

`ifdef ECC_WRAP_TIMEOUT_EN
    task automatic test_timeout();
        load_b(1, 1, 2'b01, 32'h5, 32'hFFFFFFFB, 32'h2, 32'h1, 32'h2, 8);
        total++; if (ib.core_start !== 1'b1) begin bad++;
            $display("FAIL to_start got=%h exp=1", ib.core_start); end
        for (int i = 0; i < 99; i++) begin
            step();
            total++; if (ib.o_err !== 1'b0 || ib.o_data_valid !== 1'b0) begin bad++;
                $display("FAIL to_wait i=%0d got=%h/%h exp=0/0", i, ib.o_err,
                         ib.o_data_valid); end
        end
        step();
        total++; if (ib.o_err !== 1'b1 || ib.o_busy !== 1'b0) begin bad++;
            $display("FAIL to_err got=%h/%h exp=1/0", ib.o_err, ib.o_busy); end
        step();
        total++; if (ib.o_err !== 1'b0 || ib.o_data_valid !== 1'b0) begin bad++;
            $display("FAIL to_after got=%h/%h exp=0/0", ib.o_err, ib.o_data_valid); end
    endtask
`endif

    initial begin
        init_inputs();
        test_reset();
        test_full_load();
        test_point_only();
        test_backpressure();
        test_illegal_mode();
        test_reset_mid_out();
`ifdef ECC_WRAP_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
